// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple dual-port RAM family and its FIFO/buffer users.
package ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // be_merge works on the widest supported word; callers size-cast in and out.
  localparam int MERGE_W    = 256;
  localparam int MERGE_BE_W = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]    old_word,
    input logic [MERGE_W-1:0]    new_word,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// Post-reset clear sequencer: walks the array once writing zero, then hands over to normal traffic.
// state | meaning
// INIT  | clear sequence running, requests ignored
// READY | normal operation
module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we,
  output logic              init_busy
);

  localparam ram_state_t        RST_STATE = INIT_ZERO ? INIT : READY;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      busy_q  <= INIT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == LAST_ADDR) begin
        state_d = READY;
        cnt_d   = '0;
      end
    end
    // busy is registered off the next state so it drops on the same edge as the last clear
    busy_d = (state_d == INIT);
  end

  always_comb begin
    clr_we    = (state_q == INIT) && !rst;
    clr_addr  = cnt_q;
    init_busy = busy_q;
  end

endmodule

// File: rtl/ram_sdp_pipe.sv
// Simple dual-port RAM with byte enables, qualified reads, 1- or 2-cycle read latency,
// selectable read-during-write policy and post-reset zero clear.
module ram_sdp_pipe
  import ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 16,
  parameter int BE_W      = DATA_W / 8,
  parameter int RD_LAT    = 1,
  parameter int RDW_MODE  = 0,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [BE_W-1:0]   w_be,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              init_busy
);

  localparam bit FWD_EN = (RDW_MODE == RDW_NEW);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] clr_addr;
  logic              clr_we;

  logic              wr_ok, rd_ok, w_in_range, r_in_range;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_word;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;

  ram_init_ctrl #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_ZERO (INIT_ZERO)
  ) u_init_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clr_addr  (clr_addr),
    .clr_we    (clr_we),
    .init_busy (init_busy)
  );

  always_comb begin
    w_in_range = (int'(w_addr) < DEPTH);
    r_in_range = (int'(r_addr) < DEPTH);
    wr_ok      = !rst && !init_busy && we && (w_be != '0) && w_in_range;
    rd_ok      = !rst && !init_busy && re;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = w_addr;
    wr_word = '0;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
    end else if (wr_ok) begin
      wr_en   = 1'b1;
      wr_word = DATA_W'(be_merge(MERGE_W'(mem_q[w_addr]), MERGE_W'(w_data), MERGE_BE_W'(w_be)));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_word;
  end

  // Stage 1 captures the read word; data holds when no read is issued.
  always_comb begin
    s1_valid_d = rd_ok;
    s1_data_d  = s1_data_q;
    if (rd_ok) begin
      s1_data_d = '0;
      if (r_in_range) begin
        s1_data_d = mem_q[r_addr];
        if (FWD_EN && wr_ok && (w_addr == r_addr))
          s1_data_d = DATA_W'(be_merge(MERGE_W'(mem_q[r_addr]), MERGE_W'(w_data), MERGE_BE_W'(w_be)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s2_valid_q, s2_valid_d;
      logic [DATA_W-1:0] s2_data_q, s2_data_d;

      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign r_valid = s2_valid_q;
      assign r_data  = s2_data_q;
    end else begin : g_lat1
      assign r_valid = s1_valid_q;
      assign r_data  = s1_data_q;
    end
  endgenerate

endmodule

// File: doc/ram_sdp_pipe.md
# ram_sdp_pipe

Simple dual-port synchronous RAM, the successor to the basic FIFO storage RAM. It adds per-byte write enables, a qualified read with a valid flag, and a selectable 1- or 2-cycle read latency. It also has a parameterised read-during-write policy and a post-reset zero-initialisation sequencer. It sits under the FIFO and buffer controllers as their storage element, and they gate traffic on `init_busy`.

## Interface
- `DATA_W`, 8: data width; must be a multiple of 8.
- `ADDR_W`, 4: address width.
- `DEPTH`, 16: number of words; 2 ≤ DEPTH ≤ 2**ADDR_W.
- `BE_W`, DATA_W/8: byte-enable width; derived, do not override.
- `RD_LAT`, 1: read latency in cycles, 1 or 2.
- `RDW_MODE`, 0: same-address read-during-write policy; 0 returns old data, 1 returns new (forwarded) data.
- `INIT_ZERO`, 1: when 1, memory is cleared after every reset; when 0, no clearing.
- `clk`, input, 1: clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `we`, input, 1: write request.
- `w_be`, input, BE_W: byte enables; bit i covers `w_data[8i+7:8i]`.
- `w_addr`, input, ADDR_W: write address.
- `w_data`, input, DATA_W: write data.
- `re`, input, 1: read request.
- `r_addr`, input, ADDR_W: read address.
- `r_data`, output, DATA_W: read data; holds its last value when no read is returned.
- `r_valid`, output, 1: one-cycle pulse qualifying `r_data`.
- `init_busy`, output, 1: high while the clear sequence runs; requests are ignored while it is high.

## Operation
- Control states:
  - INIT: clear sequence in progress.
  - READY: normal operation.
- Reset behaviour, on any edge with `rst`=1:
  - state ← INIT if INIT_ZERO=1, otherwise READY.
  - Init counter ← 0.
  - `r_valid` ← 0 and `r_data` ← 0, including the internal pipeline stage.
  - `init_busy` ← INIT_ZERO.
- INIT: each edge with `rst`=0 writes all-zero to `mem[cnt]` and increments `cnt`.
  - The edge that writes DEPTH-1 moves the state to READY and clears `init_busy`.
  - `we` and `re` are ignored; no `r_valid` is produced.
- Reset mid-INIT restarts the sequence from address 0.
- Reset in READY aborts any in-flight read: the pending `r_valid` is dropped.
- Writes (READY): on an edge with `we`=1, each byte i with `w_be[i]`=1 is updated; other bytes are unchanged.
  - `w_be`=0 is a no-op.
  - `w_addr` ≥ DEPTH: the write is dropped silently.
- Reads (READY): `re`=1 samples `r_addr` and returns `mem[r_addr]` after RD_LAT edges, with `r_valid`=1 for exactly one cycle.
  - Back-to-back reads give one result per cycle, in order.
  - `r_addr` ≥ DEPTH returns all-zero data, still with `r_valid`=1.
- Read and write in the same cycle:
  - Different addresses: fully independent.
  - Same address, RDW_MODE=0: the read returns the pre-write word.
  - Same address, RDW_MODE=1: the read returns the post-write word, i.e. enabled bytes from `w_data` and the rest from memory.
- With RD_LAT=2, a write in the cycle after a read to the same address does not alter the data already captured in stage 1.

## Timing
- RD_LAT=1: `re` sampled at edge N gives `r_data`/`r_valid` valid after edge N, visible during cycle N+1.
- RD_LAT=2: one additional register stage; valid after edge N+1.
- A write at edge N is visible to a read sampled at edge N+1 or later, in either mode.
- INIT duration: exactly DEPTH cycles after the first edge with `rst`=0.
- A request presented in the cycle where `init_busy` has just fallen is accepted.
- No combinational path from any input to any output. `r_valid` and `init_busy` are registered.

## Structure
- Shared package `ram_pkg`:
  - State enum `ram_state_t` {INIT, READY}.
  - Constants `RDW_OLD`=0 and `RDW_NEW`=1.
  - Function `be_merge(old, new, be)` returning the byte-masked merged word; also used by the FIFO controllers.
- Sub-module `ram_init_ctrl`: the INIT/READY FSM plus the clear counter. Outputs the clear address, clear write strobe and `init_busy`.
- The top level holds the array, the byte-enable write path, the RDW mux and the RD_LAT-generated pipeline.

## Test plan
- Reset then clear: DEPTH=16, INIT_ZERO=1, one reset cycle.
  - Required: `init_busy`=1 for 16 cycles, then 0.
  - Required: reads of addresses 0..15 return 0x00 with `r_valid` pulses.
  - Required: a write attempted during INIT (addr 3, 0xAA) has no effect.
- Byte enables: DATA_W=32; write 0x11223344 with be=4'hF to addr 5, then 0xAABBCCDD with be=4'b0101 to addr 5.
  - Required: a read of addr 5 returns 0x11BB33DD.
- Read during write: same-address read and write of 0x5A over 0x3C.
  - Required: RDW_MODE=0 returns 0x3C; RDW_MODE=1 returns 0x5A. Both read 0x5A on the next cycle.
- Latency and streaming: RD_LAT=2, `re` held for 4 cycles on addresses 0,1,2,3 preloaded with 0xA0..0xA3.
  - Required: `r_valid` high for 4 consecutive cycles starting 2 edges after the first `re`, data in order.
- Out of range: DEPTH=12, ADDR_W=4; write 0xFF to addr 13, read addr 13.
  - Required: 0x00 returned with `r_valid`, and addresses 0..11 unchanged.
- Reset mid-operation: assert `rst` with a read in flight, and separately at INIT count 7.
  - Required: no `r_valid` pulse; `r_data`=0; INIT restarts and again lasts exactly DEPTH cycles.
